// File: rtl/hls_stream_arbiter.sv
// Frame-level round-robin arbiter: NUM_REQ read FIFOs share one ap_fifo stream through a 2-entry buffer.
// FIFO rd_en to in_r_empty_n takes 2 cycles; reads stop once buffer plus in-flight reach 2. Counters: HLS_ARB_STATS_EN.
module hls_stream_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DW = 32,
  parameter int LEN_W = 16,
  parameter logic [DW-1:0] PAD_WORD = '0
) (
  input  logic                    bus_clk,
  input  logic                    bus_rst_n,
  input  logic [NUM_REQ*DW-1:0]   req_dout,
  input  logic [NUM_REQ-1:0]      req_empty,
  input  logic [NUM_REQ-1:0]      req_open,
  output logic [NUM_REQ-1:0]      req_rd_en,
  output logic [DW-1:0]           in_r_dout,
  output logic                    in_r_empty_n,
  input  logic                    in_r_read,
  output logic [NUM_REQ-1:0]      grant,
  output logic                    busy
`ifdef HLS_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]   frame_cnt,
  output logic [15:0]             abort_cnt
`endif
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [2:0] S_IDLE = 3'd0, S_HDR = 3'd1, S_PAYLOAD = 3'd2, S_PAD = 3'd3, S_DRAIN = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d, rr_q, rr_d, pick;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               hdr_iss_q, hdr_iss_d, pend_q;
  logic [LEN_W-1:0]   words_q, words_d;
  logic [DW-1:0]      buf0_q, buf1_q, push_dat, cur_dat;
  logic [1:0]         cnt_q, wpos;
  logic [2:0]         occ;
  logic               found, pop, push, room, rd_fire, cur_open, cur_empty;

  always_comb begin
    found = 1'b0;
    pick  = rr_q;
    // Descending scan so the candidate closest to rr_q wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_open[(int'(rr_q) + k) % NUM_REQ] && !req_empty[(int'(rr_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        pick  = IW'((int'(rr_q) + k) % NUM_REQ);
      end
    end
  end

  assign cur_open  = req_open[idx_q];
  assign cur_empty = req_empty[idx_q];
  assign cur_dat   = req_dout[idx_q*DW +: DW];
  assign pop       = in_r_read && (cnt_q != 2'd0);
  assign occ       = {1'b0, cnt_q} + {2'b0, pend_q} - {2'b0, pop};
  assign room      = occ < 3'd2;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rr_d      = rr_q;
    grant_d   = grant_q;
    hdr_iss_d = hdr_iss_q;
    words_d   = words_q;
    rd_fire   = 1'b0;
    push      = 1'b0;
    push_dat  = cur_dat;
    case (state_q)
      S_IDLE: if (found) begin
        idx_d     = pick;
        grant_d   = NUM_REQ'(1) << pick;
        hdr_iss_d = 1'b0;
        state_d   = S_HDR;
      end
      S_HDR: begin
        if (!cur_open) begin
          state_d = S_DRAIN;
        end else if (pend_q) begin
          push    = 1'b1;
          words_d = cur_dat[LEN_W-1:0];
          state_d = (cur_dat[LEN_W-1:0] == '0) ? S_DRAIN : S_PAYLOAD;
        end else if (!hdr_iss_q && !cur_empty && room) begin
          rd_fire   = 1'b1;
          hdr_iss_d = 1'b1;
        end
      end
      S_PAYLOAD: begin
        // A close discards the in-flight word; it is still owed, so it gets padded.
        if (!cur_open) begin
          state_d = S_PAD;
        end else begin
          if (pend_q) begin
            push    = 1'b1;
            words_d = words_q - 1'b1;
            if (words_q == LEN_W'(1)) state_d = S_DRAIN;
          end
          rd_fire = !cur_empty && (words_q > LEN_W'(pend_q)) && room;
        end
      end
      S_PAD: if (room) begin
        push     = 1'b1;
        push_dat = PAD_WORD;
        words_d  = words_q - 1'b1;
        if (words_q == LEN_W'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: if (cnt_q == 2'd0) begin
        rr_d    = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wpos = cnt_q - {1'b0, pop};

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      rr_q      <= '0;
      grant_q   <= '0;
      hdr_iss_q <= 1'b0;
      pend_q    <= 1'b0;
      words_q   <= '0;
      buf0_q    <= '0;
      buf1_q    <= '0;
      cnt_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      hdr_iss_q <= hdr_iss_d;
      pend_q    <= rd_fire;
      words_q   <= words_d;
      cnt_q     <= cnt_q - {1'b0, pop} + {1'b0, push};
      if (pop) buf0_q <= buf1_q;
      if (push) begin
        if (wpos == 2'd0) buf0_q <= push_dat;
        else              buf1_q <= push_dat;
      end
    end
  end

  assign req_rd_en    = rd_fire ? (NUM_REQ'(1) << idx_q) : '0;
  assign in_r_dout    = buf0_q;
  assign in_r_empty_n = (cnt_q != 2'd0);
  assign grant        = grant_q;
  assign busy         = (state_q != S_IDLE);

`ifdef HLS_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] frame_cnt_q;
  logic [15:0]           abort_cnt_q;
  logic                  in_frame, abort_ev, done_ev;

  assign in_frame = (state_q == S_HDR) || (state_q == S_PAYLOAD);
  assign abort_ev = in_frame && !cur_open;
  assign done_ev  = in_frame && cur_open && (state_d == S_DRAIN);

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      frame_cnt_q <= '0;
      abort_cnt_q <= '0;
    end else begin
      if (done_ev) frame_cnt_q[int'(idx_q)*16 +: 16] <= frame_cnt_q[int'(idx_q)*16 +: 16] + 16'd1;
      if (abort_ev && abort_cnt_q != 16'hFFFF) abort_cnt_q <= abort_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign abort_cnt = abort_cnt_q;
`endif

endmodule

// File: tb/tb_hls_stream_arbiter.sv
// Directed + randomized bench for hls_stream_arbiter with FIFO models and a frame-level round-robin reference.
module tb_hls_stream_arbiter;
  localparam int NR = 2;
  localparam int DW = 32;
  localparam logic [31:0] PADW = 32'hDEAD_BEEF;

  logic bus_clk = 1'b0;
  logic bus_rst_n;
  logic [NR*DW-1:0] req_dout;
  logic [NR-1:0] req_empty, req_open, req_rd_en, grant;
  logic [DW-1:0] in_r_dout;
  logic in_r_empty_n, in_r_read, busy;
`ifdef HLS_ARB_STATS_EN
  logic [NR*16-1:0] frame_cnt;
  logic [15:0] abort_cnt;
`endif

  always #5 bus_clk = ~bus_clk;

  hls_stream_arbiter #(.NUM_REQ(NR), .DW(DW), .LEN_W(16), .PAD_WORD(PADW)) dut (
    .bus_clk(bus_clk), .bus_rst_n(bus_rst_n),
    .req_dout(req_dout), .req_empty(req_empty), .req_open(req_open), .req_rd_en(req_rd_en),
    .in_r_dout(in_r_dout), .in_r_empty_n(in_r_empty_n), .in_r_read(in_r_read),
    .grant(grant), .busy(busy)
`ifdef HLS_ARB_STATS_EN
    , .frame_cnt(frame_cnt), .abort_cnt(abort_cnt)
`endif
  );

  logic [31:0] fq[NR][$];
  int          mlen[NR][$];
  logic [31:0] mw[NR][$];
  int          m_rr;
  logic [31:0] exp_d[$];
  int          exp_s[$];
  logic [31:0] got_d[$];
  logic [NR-1:0] got_g[$];
  int n_assert = 0, n_fail = 0;
  int rd_total = 0, pop_total = 0;
  logic [NR-1:0] rd_s;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NR; i++) req_empty[i] = (fq[i].size() == 0);
  endtask

  task automatic tick();
    @(negedge bus_clk);
    chk("rd_onehot", 64'($countones(req_rd_en) <= 1), 1);
    chk("grant_onehot", 64'($countones(grant) <= 1), 1);
    chk("rd_owner", 64'(req_rd_en & ~grant), 0);
    chk("rd_empty", 64'(req_rd_en & req_empty), 0);
    rd_s = req_rd_en;
    rd_total += $countones(req_rd_en);
    if (in_r_empty_n && in_r_read) begin
      got_d.push_back(in_r_dout);
      got_g.push_back(grant);
      pop_total++;
    end
    @(posedge bus_clk);
    #1;
    for (int i = 0; i < NR; i++)
      if (rd_s[i] && fq[i].size() > 0) req_dout[i*DW +: DW] = fq[i].pop_front();
    refresh();
  endtask

  task automatic load_frame(input int src, input int n);
    logic [31:0] w;
    w = $urandom();
    w[15:0] = 16'(n);
    fq[src].push_back(w);
    mw[src].push_back(w);
    for (int k = 0; k < n; k++) begin
      w = $urandom();
      fq[src].push_back(w);
      mw[src].push_back(w);
    end
    mlen[src].push_back(n);
    refresh();
  endtask

  // Whole frames in round-robin order starting at the model pointer.
  task automatic build_expected();
    int s, n;
    while (mlen[0].size() + mlen[1].size() > 0) begin
      s = m_rr;
      for (int k = NR - 1; k >= 0; k--)
        if (mlen[(m_rr + k) % NR].size() > 0) s = (m_rr + k) % NR;
      n = mlen[s].pop_front();
      for (int j = 0; j <= n; j++) begin
        exp_d.push_back(mw[s].pop_front());
        exp_s.push_back(s);
      end
      m_rr = (s + 1) % NR;
    end
  endtask

  task automatic run_compare(input string tag, input bit rand_rd, input int budget);
    int t = 0;
    while (got_d.size() < exp_d.size() && t < budget) begin
      if (rand_rd) in_r_read = ($urandom_range(0, 3) != 0);
      tick();
      t++;
    end
    in_r_read = 1'b1;
    chk({tag, "_count"}, 64'(got_d.size()), 64'(exp_d.size()));
    for (int j = 0; j < exp_d.size() && j < got_d.size(); j++) begin
      chk({tag, "_data"}, 64'(got_d[j]), 64'(exp_d[j]));
      chk({tag, "_grant"}, 64'(got_g[j]), 64'(NR'(1) << exp_s[j]));
    end
    t = 0;
    while (busy && t < 50) begin
      tick();
      t++;
    end
    chk({tag, "_idle_busy"}, 64'(busy), 0);
    chk({tag, "_idle_grant"}, 64'(grant), 0);
    chk({tag, "_idle_valid"}, 64'(in_r_empty_n), 0);
    exp_d.delete(); exp_s.delete(); got_d.delete(); got_g.delete();
  endtask

  initial begin
    int rd_b, pop_b, g0;
    bus_rst_n = 1'b0;
    in_r_read = 1'b0;
    req_open  = '1;
    req_dout  = '0;
    refresh();
    m_rr = 0;
    #12;
    chk("rst_rd_en", 64'(req_rd_en), 0);
    chk("rst_dout", 64'(in_r_dout), 0);
    chk("rst_valid", 64'(in_r_empty_n), 0);
    chk("rst_grant", 64'(grant), 0);
    chk("rst_busy", 64'(busy), 0);
    @(posedge bus_clk);
    #1 bus_rst_n = 1'b1;
    tick(); tick();

    in_r_read = 1'b1;
    load_frame(0, 3);
    build_expected();
    run_compare("single", 1'b0, 100);

    load_frame(0, 2); load_frame(0, 2); load_frame(1, 2); load_frame(1, 2);
    build_expected();
    run_compare("alternate", 1'b0, 200);

    load_frame(0, 6); load_frame(1, 3);
    build_expected();
    rd_b = rd_total;
    pop_b = pop_total;
    in_r_read = 1'b1;
    tick(); tick(); tick();
    in_r_read = 1'b0;
    g0 = got_d.size();
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_outstanding", 64'(((rd_total - rd_b) - (pop_total - pop_b)) <= 2), 1);
    end
    chk("bp_hold", 64'(got_d.size()), 64'(g0));
    chk("bp_valid", 64'(in_r_empty_n), 1);
    in_r_read = 1'b1;
    run_compare("backpressure", 1'b0, 200);

    for (int f = 0; f < 6; f++) load_frame($urandom_range(0, 1), $urandom_range(0, 5));
    build_expected();
    run_compare("random", 1'b1, 600);

    begin
      logic [31:0] w;
      w = $urandom();
      w[15:0] = 16'd5;
      fq[1].push_back(w); exp_d.push_back(w); exp_s.push_back(1);
      for (int k = 0; k < 2; k++) begin
        w = $urandom();
        fq[1].push_back(w); exp_d.push_back(w); exp_s.push_back(1);
      end
      for (int k = 0; k < 3; k++) begin
        exp_d.push_back(PADW); exp_s.push_back(1);
      end
      refresh();
    end
    in_r_read = 1'b1;
    for (int c = 0; c < 15; c++) tick();
    chk("abort_pre_count", 64'(got_d.size()), 3);
    chk("abort_pre_busy", 64'(busy), 1);
    req_open[1] = 1'b0;
    run_compare("abort", 1'b0, 100);
    m_rr = 0;
`ifdef HLS_ARB_STATS_EN
    chk("abort_cnt", 64'(abort_cnt), 1);
`endif
    req_open[1] = 1'b1;

    load_frame(0, 0); load_frame(1, 2);
    build_expected();
    run_compare("zero_len", 1'b0, 100);

    load_frame(0, 8);
    in_r_read = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    chk("rst_mid_busy", 64'(busy), 1);
    #2 bus_rst_n = 1'b0;
    #1;
    chk("rst_mid_rd_en", 64'(req_rd_en), 0);
    chk("rst_mid_valid", 64'(in_r_empty_n), 0);
    chk("rst_mid_dout", 64'(in_r_dout), 0);
    chk("rst_mid_grant", 64'(grant), 0);
    chk("rst_mid_busy0", 64'(busy), 0);
    for (int i = 0; i < NR; i++) begin
      fq[i].delete(); mw[i].delete(); mlen[i].delete();
    end
    got_d.delete(); got_g.delete();
    refresh();
    tick(); tick();
    bus_rst_n = 1'b1;
    m_rr = 0;
    load_frame(1, 3);
    build_expected();
    run_compare("post_reset", 1'b0, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
